clk_sel_ctrl: RTL and testbench

Control stage that drives the select input of the glitch-free clock mux (`clk_sel`), which switches between the normal and turbo CPU clocks. It accepts switch requests over a valid/ready handshake, waits for a CPU bus-safe point, and toggles the select. It then holds off further requests for a settle window and a minimum dwell window, so the mux handover always completes and the clock cannot be thrashed.

---
 rtl/clk_sel_ctrl.sv | 115 +++++++++++
 tb/tb_clk_sel_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl
// Drives the select input of the glitch-free CPU clock mux (normal clk1 vs
// turbo clk2). A switch request is taken over a valid/ready handshake. The
// select toggles only at a CPU bus-safe point. After the toggle, a settle
// window and then a dwell window must pass before another request is accepted.
//
// Ports:
//   i_clk          control clock (free-running, independent of mux sources)
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    switch request valid
//   i_req_turbo    requested select: 0 = clk1 (normal), 1 = clk2 (turbo)
//   o_req_ready    request accepted on a cycle with valid & ready
//   i_bus_idle     CPU at a safe point, synchronous to i_clk
//   o_sel          registered select to the mux
//   o_busy         a switch is pending or settling
//   o_switch_pulse one-cycle strobe on the cycle o_sel changes
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request; a request for the current select is a no-op
// WAIT_SAFE | target latched, waiting for i_bus_idle before toggling o_sel
// SETTLE    | mux handover in progress; counter runs down SETTLE_CYCLES
// HOLD      | minimum dwell; counter runs down DWELL_CYCLES, requests ignored

module clk_sel_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_valid,
  input  logic i_req_turbo,
  output logic o_req_ready,
  input  logic i_bus_idle,
  output logic o_sel,
  output logic o_busy,
  output logic o_switch_pulse
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SAFE,
    SETTLE,
    HOLD
  } state_t;

  state_t           state;
  logic             target;
  logic [CNT_W-1:0] cnt;

  // o_req_ready and o_busy are registered alongside the state so the mux
  // side only ever sees flop outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      target         <= 1'b0;
      cnt            <= '0;
      o_sel          <= 1'b0;
      o_req_ready    <= 1'b1;
      o_busy         <= 1'b0;
      o_switch_pulse <= 1'b0;
    end else begin
      o_switch_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // A request for the select already in force completes immediately.
          if (i_req_valid && (i_req_turbo != o_sel)) begin
            target      <= i_req_turbo;
            state       <= WAIT_SAFE;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
          end
        end
        WAIT_SAFE: begin
          if (i_bus_idle) begin
            o_sel          <= target;
            o_switch_pulse <= 1'b1;
            cnt            <= SETTLE_LOAD;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            cnt    <= DWELL_LOAD;
            state  <= HOLD;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state       <= IDLE;
            o_req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl
// Self-checking bench for clk_sel_ctrl. Expected outputs come from a timeline
// model: it remembers the edge index of the last select change and whether a
// switch is pending. From those it derives ready, busy and pulse with plain
// arithmetic on edge counts. Directed scenarios run first, then randomized
// traffic with occasional asynchronous resets.

module tb_clk_sel_ctrl;

  localparam int SETTLE = 4;
  localparam int DWELL  = 8;

  logic i_clk       = 1'b0;
  logic i_rst_n     = 1'b0;
  logic i_req_valid = 1'b0;
  logic i_req_turbo = 1'b0;
  logic i_bus_idle  = 1'b0;
  logic o_req_ready;
  logic o_sel;
  logic o_busy;
  logic o_switch_pulse;

  clk_sel_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .i_req_turbo   (i_req_turbo),
    .o_req_ready   (o_req_ready),
    .i_bus_idle    (i_bus_idle),
    .o_sel         (o_sel),
    .o_busy        (o_busy),
    .o_switch_pulse(o_switch_pulse)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Timeline model
  int cyc = 0;
  int t_sw;
  bit m_sel;
  bit m_pending;
  bit m_target;

  function automatic void model_reset();
    m_sel     = 1'b0;
    m_pending = 1'b0;
    m_target  = 1'b0;
    t_sw      = -100000;
  endfunction

  function automatic bit ready_at(input int c);
    return !m_pending && (c >= t_sw + SETTLE + DWELL);
  endfunction

  function automatic bit busy_at(input int c);
    return m_pending || (c < t_sw + SETTLE);
  endfunction

  // Called right after a rising edge, with the inputs still at the values
  // they held across that edge.
  function automatic void model_edge();
    bit rdy_before;
    rdy_before = ready_at(cyc);
    cyc++;
    if (m_pending) begin
      if (i_bus_idle) begin
        m_sel     = m_target;
        t_sw      = cyc;
        m_pending = 1'b0;
      end
    end else if (rdy_before && i_req_valid && (i_req_turbo != m_sel)) begin
      m_pending = 1'b1;
      m_target  = i_req_turbo;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ":sel"},   o_sel,          m_sel);
    check_val({tag, ":ready"}, o_req_ready,    ready_at(cyc));
    check_val({tag, ":busy"},  o_busy,         busy_at(cyc));
    check_val({tag, ":pulse"}, o_switch_pulse, (cyc == t_sw));
  endtask

  task automatic step(input string tag);
    @(posedge i_clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic wait_ready();
    i_req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_at(cyc)) break;
      step("wait_ready");
    end
  endtask

  // Asserts reset between clock edges and checks that the outputs follow at once.
  task automatic async_reset(input string tag);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_val({tag, ":rst_sel"},   o_sel,          1'b0);
    check_val({tag, ":rst_busy"},  o_busy,         1'b0);
    check_val({tag, ":rst_ready"}, o_req_ready,    1'b1);
    check_val({tag, ":rst_pulse"}, o_switch_pulse, 1'b0);
    model_reset();
    #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;

    model_reset();

    // Reset state, then quiet for 10 cycles
    #12;
    check_val("reset:sel",   o_sel,          1'b0);
    check_val("reset:ready", o_req_ready,    1'b1);
    check_val("reset:busy",  o_busy,         1'b0);
    check_val("reset:pulse", o_switch_pulse, 1'b0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("quiet");

    // Best-case switch to turbo with the bus idle
    i_bus_idle  = 1'b1;
    i_req_valid = 1'b1;
    i_req_turbo = 1'b1;
    step("best_e0");
    i_req_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step("best");
      if (k == 1) begin
        check_val("best:sel_e1",   o_sel,          1'b1);
        check_val("best:pulse_e1", o_switch_pulse, 1'b1);
      end
      if (k == 2)  check_val("best:pulse_e2", o_switch_pulse, 1'b0);
      if (k == 4)  check_val("best:busy_e4",  o_busy,         1'b1);
      if (k == 5)  check_val("best:busy_e5",  o_busy,         1'b0);
      if (k == 12) check_val("best:ready_e12", o_req_ready,   1'b0);
      if (k == 13) check_val("best:ready_e13", o_req_ready,   1'b1);
    end

    // Bus busy for 20 cycles after accept; the late turbo change is ignored
    i_bus_idle  = 1'b0;
    i_req_valid = 1'b1;
    i_req_turbo = 1'b0;
    step("safe_e0");
    i_req_valid = 1'b0;
    i_req_turbo = 1'b1;
    for (int i = 0; i < 20; i++) step("safe_wait");
    i_bus_idle = 1'b1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step("safe_go");
      pulses += int'(o_switch_pulse);
    end
    check_val("safe:pulse_count", pulses, 1);
    check_val("safe:sel_final",   o_sel,  1'b0);

    // No-op request back to back
    i_req_valid = 1'b1;
    i_req_turbo = 1'b0;
    step("noop1");
    check_val("noop1:ready", o_req_ready, 1'b1);
    step("noop2");
    check_val("noop2:ready", o_req_ready, 1'b1);
    check_val("noop2:busy",  o_busy,      1'b0);
    i_req_valid = 1'b0;

    // Held request with alternating target while not ready
    i_req_valid = 1'b1;
    i_req_turbo = 1'b1;
    step("alt_e0");
    for (int i = 0; i < 24; i++) begin
      i_req_turbo = ~i_req_turbo;
      step("alt");
    end
    i_req_valid = 1'b0;

    // Reset in the middle of SETTLE with o_sel=1, then normal operation
    wait_ready();
    if (m_sel) begin
      i_bus_idle  = 1'b1;
      i_req_valid = 1'b1;
      i_req_turbo = 1'b0;
      step("pre_rst");
      i_req_valid = 1'b0;
      step("pre_rst");
      wait_ready();
    end
    i_bus_idle  = 1'b1;
    i_req_valid = 1'b1;
    i_req_turbo = 1'b1;
    step("mid_e0");
    i_req_valid = 1'b0;
    step("mid_e1");
    check_val("mid:sel_before_rst", o_sel, 1'b1);
    step("mid_e2");
    step("mid_e3");
    async_reset("mid");
    i_req_valid = 1'b1;
    i_req_turbo = 1'b1;
    step("post_rst_e0");
    i_req_valid = 1'b0;
    step("post_rst_e1");
    check_val("post_rst:sel", o_sel, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      i_req_valid = ($urandom_range(0, 3) != 0);
      i_req_turbo = 1'($urandom_range(0, 1));
      i_bus_idle  = ($urandom_range(0, 2) == 0);
      step("rand");
      if ($urandom_range(0, 499) == 0) async_reset("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
